fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Instruction-fetch controller sitting between the memory arbiter and the instruction queue. It owns the architectural fetch PC and requests one 32-bit instruction word at a time from memory. Each returned word is pushed into the instruction queue, paired with its PC, and only while the queue reports space. On a pipeline `clear` it redirects to a new PC and discards any in-flight word. An optional direct-mapped instruction cache removes the memory round trip on hits.

## Interface
Parameters:
- `RESET_PC`, 32'h0: fetch PC after reset.
- `ICACHE_IDX_W`, 4: log2 of icache line count. Only used with the cache compiled in.

Ports:
- `clk_in`, input, 1: the single clock.
- `rst_in`, input, 1: asynchronous, active-high reset.
- `rdy_in`, input, 1: global enable. When low, all state freezes.
- `clear`, input, 1: pipeline flush or redirect request.
- `clear_pc`, input, 32: redirect target. Sampled when `clear` is high.
- `mem_req`, output, 1: word read request to the memory arbiter.
- `mem_addr`, output, 32: word address, always 4-byte aligned.
- `mem_ack`, input, 1: one-cycle pulse; `mem_data` is valid in that cycle.
- `mem_data`, input, 32: returned instruction word.
- `iq_wr_en`, input, 1: high when the instruction queue can accept a push (at least 2 free slots).
- `inst_valid`, output, 1: one-cycle push strobe to the queue.
- `inst_out`, output, 32: instruction word being pushed.
- `pc_out`, output, 32: PC of `inst_out`.

## Operation
- Reset values: PC=`RESET_PC`, state=IDLE, `mem_req`=0, `mem_addr`=0, `inst_valid`=0, `inst_out`=0, `pc_out`=0, and all icache valid bits 0.
- IDLE:
  - If `iq_wr_en`=1 and there is no icache hit: set `mem_req`=1 and `mem_addr`=PC, then go to WAIT.
  - If `iq_wr_en`=1 and the icache hits: set `inst_valid`=1, `inst_out`=cached word, `pc_out`=PC, PC+=4, and stay in IDLE.
  - If `iq_wr_en`=0: stay in IDLE.
- WAIT: hold `mem_req` and `mem_addr` stable until `mem_ack`. On ack:
  - With `iq_wr_en`=1: push the word, PC+=4, go to IDLE.
  - With `iq_wr_en`=0: latch the word into the hold register, go to HOLD.
- HOLD: when `iq_wr_en`=1, push the held word, PC+=4, go to IDLE.
- DRAIN: keep `mem_req` high until `mem_ack`. Discard the data, do not fill the cache, then go to IDLE.
- `clear` (highest priority, any state): PC←`clear_pc` and `inst_valid`=0 in the next cycle.
  - WAIT goes to DRAIN, because a memory transaction is never abandoned mid-flight.
  - DRAIN stays in DRAIN; the target is updated to the latest `clear_pc`.
  - HOLD and IDLE go to IDLE; a held word is discarded.
- `clear` coincident with `mem_ack` in WAIT: the word is discarded and the next state is IDLE, not DRAIN.
- `mem_ack` is ignored in IDLE and HOLD.
- PC arithmetic is 32-bit and wraps modulo 2^32 (32'hFFFFFFFC + 4 = 0).
- `rdy_in`=0: no state, PC, or output register changes, except `inst_valid`, which is forced to 0.
- `inst_valid` is registered and never high for two consecutive cycles with the same `pc_out`.

## Timing
- Miss: `mem_req` rises 1 cycle after IDLE sees `iq_wr_en`=1. With `mem_ack` in cycle N, `inst_valid` is high in cycle N+1.
- Hit: `inst_valid` is high 1 cycle after the IDLE decision. Sustained throughput is 1 instruction per cycle.
- HOLD release: `inst_valid` is high 1 cycle after `iq_wr_en` returns high.
- Redirect: the first `mem_req` at `clear_pc` appears no earlier than 2 cycles after `clear` from IDLE. From WAIT, it appears 2 cycles after the drain ack.
- Reset: asynchronous assertion clears all state immediately, including in WAIT. On deassertion the block starts in IDLE.

## Configuration
- `ICACHE_EN` defined: a direct-mapped cache of 2^`ICACHE_IDX_W` one-word lines.
  - Index = PC[`ICACHE_IDX_W`+1:2]; tag = PC[31:`ICACHE_IDX_W`+2].
  - Lookup is combinational in IDLE.
  - A line is filled on every non-discarded `mem_ack`.
  - Valid bits are cleared only by reset; `clear` does not invalidate.
- `ICACHE_EN` undefined: the hit term is constant 0 and no cache storage exists. Every fetch goes through WAIT.

## Structure
- The shared definitions header holds:
  - the state encodings FC_IDLE, FC_WAIT, FC_HOLD, FC_DRAIN (2-bit);
  - the 32-bit word and address width macros;
  - the `one`/`zero` constants.
- One sub-module, `icache_dm`. Inputs: lookup address, fill strobe, fill address and fill data. Outputs: hit and word. It is instantiated only under `ICACHE_EN`.

## Test plan
- Reset with `RESET_PC`=0, `iq_wr_en`=1, memory ack 3 cycles after each req → `mem_addr` sequence 0x0, 0x4, 0x8, and each `inst_valid` is 1 cycle after its ack with the matching `pc_out`.
- In WAIT, hold `iq_wr_en`=0 at ack of 0x4 → enter HOLD with no push. Raise `iq_wr_en` 5 cycles later → single push, `pc_out`=0x4.
- `clear` with `clear_pc`=0x100 during WAIT for 0x8 → `mem_req` stays high until ack, that word is not pushed, and the next `mem_addr`=0x100.
- `clear` in the same cycle as `mem_ack` → no push, no DRAIN, and the next request is to `clear_pc`.
- `ICACHE_EN`: fetch 0x0–0xC, then `clear` to 0x0 → four pushes on consecutive cycles with `mem_req` low throughout.
- `rdy_in`=0 for 4 cycles mid-WAIT with `mem_ack` held off → `mem_req` and `mem_addr` are unchanged and `inst_valid`=0. The block resumes correctly when `rdy_in` returns.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch controller: state encoding,
// datapath widths, single-bit constants and PC arithmetic.
package fetch_ctrl_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned ADDR_W = 32;

  localparam logic ONE  = 1'b1;
  localparam logic ZERO = 1'b0;

  localparam logic [ADDR_W-1:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    FC_IDLE  = 2'd0,
    FC_WAIT  = 2'd1,
    FC_HOLD  = 2'd2,
    FC_DRAIN = 2'd3
  } fc_state_e;

  // Wraps modulo 2^32.
  function automatic logic [ADDR_W-1:0] pc_next(input logic [ADDR_W-1:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/fetch_ctrl_icache_dm.sv
// Direct-mapped one-word-per-line instruction cache; only built when ICACHE_EN
// is defined. Valid bits are cleared by reset only.
`ifdef ICACHE_EN
module icache_dm
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned IDX_W = 4
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [ADDR_W-1:0] lookup_addr,
  input  logic              fill_en,
  input  logic [ADDR_W-1:0] fill_addr,
  input  logic [WORD_W-1:0] fill_data,
  output logic              hit,
  output logic [WORD_W-1:0] word
);

  localparam int unsigned LINES = 1 << IDX_W;
  localparam int unsigned TAG_W = ADDR_W - IDX_W - 2;

  logic [LINES-1:0]  valid_q, valid_d;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [WORD_W-1:0] data_q [LINES];

  logic [IDX_W-1:0] lk_idx, fill_idx;
  logic [TAG_W-1:0] lk_tag, fill_tag;
  logic             unused_ok;

  assign lk_idx    = lookup_addr[IDX_W+1:2];
  assign lk_tag    = lookup_addr[ADDR_W-1:IDX_W+2];
  assign fill_idx  = fill_addr[IDX_W+1:2];
  assign fill_tag  = fill_addr[ADDR_W-1:IDX_W+2];
  assign unused_ok = ^{lookup_addr[1:0], fill_addr[1:0]};

  always_comb begin
    valid_d = valid_q;
    if (fill_en) valid_d[fill_idx] = ONE;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) valid_q <= '0;
    else        valid_q <= valid_d;
  end

  // Tag/data arrays need no reset: a line is only consulted once its valid bit is set.
  always_ff @(posedge clk_in) begin
    if (fill_en) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= fill_data;
    end
  end

  assign hit  = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign word = data_q[lk_idx];

endmodule
`endif

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: owns the fetch PC, issues one-word memory reads and
// pushes words into the instruction queue. Define ICACHE_EN to build in icache_dm.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC     = 32'h0,
  parameter int unsigned       ICACHE_IDX_W = 4
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              clear,
  input  logic [ADDR_W-1:0] clear_pc,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [WORD_W-1:0] mem_data,
  input  logic              iq_wr_en,
  output logic              inst_valid,
  output logic [WORD_W-1:0] inst_out,
  output logic [ADDR_W-1:0] pc_out
);

  fc_state_e         state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              inst_valid_q, inst_valid_d;
  logic [WORD_W-1:0] inst_out_q, inst_out_d;
  logic [ADDR_W-1:0] pc_out_q, pc_out_d;
  logic [WORD_W-1:0] hold_q, hold_d;

  logic              push;
  logic [WORD_W-1:0] push_word;
  logic              cache_hit;
  logic [WORD_W-1:0] cache_word;
  logic              fill_en;
  logic [ADDR_W-1:0] redirect_pc;
  logic              unused_ok;

  assign redirect_pc = {clear_pc[ADDR_W-1:2], 2'b00};
  assign fill_en     = rdy_in && !clear && (state_q == FC_WAIT) && mem_ack;

`ifdef ICACHE_EN
  icache_dm #(
    .IDX_W (ICACHE_IDX_W)
  ) u_icache (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .lookup_addr (pc_q),
    .fill_en     (fill_en),
    .fill_addr   (mem_addr_q),
    .fill_data   (mem_data),
    .hit         (cache_hit),
    .word        (cache_word)
  );
  assign unused_ok = ^clear_pc[1:0];
`else
  assign cache_hit  = ZERO;
  assign cache_word = '0;
  assign unused_ok  = ^{clear_pc[1:0], fill_en, 32'(ICACHE_IDX_W)};
`endif

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    inst_valid_d = ZERO;
    inst_out_d   = inst_out_q;
    pc_out_d     = pc_out_q;
    hold_d       = hold_q;
    push         = ZERO;
    push_word    = '0;

    if (rdy_in) begin
      if (clear) begin
        pc_d = redirect_pc;
        case (state_q)
          // An outstanding read must complete; an ack arriving now finishes it.
          FC_WAIT, FC_DRAIN: begin
            if (mem_ack) begin
              mem_req_d = ZERO;
              state_d   = FC_IDLE;
            end else begin
              state_d   = FC_DRAIN;
            end
          end
          default: state_d = FC_IDLE;
        endcase
      end else begin
        case (state_q)
          FC_IDLE: begin
            if (iq_wr_en) begin
              if (cache_hit) begin
                push      = ONE;
                push_word = cache_word;
              end else begin
                mem_req_d  = ONE;
                mem_addr_d = pc_q;
                state_d    = FC_WAIT;
              end
            end
          end
          FC_WAIT: begin
            if (mem_ack) begin
              mem_req_d = ZERO;
              if (iq_wr_en) begin
                push      = ONE;
                push_word = mem_data;
                state_d   = FC_IDLE;
              end else begin
                hold_d    = mem_data;
                state_d   = FC_HOLD;
              end
            end
          end
          FC_HOLD: begin
            if (iq_wr_en) begin
              push      = ONE;
              push_word = hold_q;
              state_d   = FC_IDLE;
            end
          end
          FC_DRAIN: begin
            if (mem_ack) begin
              mem_req_d = ZERO;
              state_d   = FC_IDLE;
            end
          end
          default: state_d = FC_IDLE;
        endcase

        if (push) begin
          inst_valid_d = ONE;
          inst_out_d   = push_word;
          pc_out_d     = pc_q;
          pc_d         = pc_next(pc_q);
        end
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q      <= FC_IDLE;
      pc_q         <= RESET_PC;
      mem_req_q    <= ZERO;
      mem_addr_q   <= '0;
      inst_valid_q <= ZERO;
      inst_out_q   <= '0;
      pc_out_q     <= '0;
      hold_q       <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      inst_valid_q <= inst_valid_d;
      inst_out_q   <= inst_out_d;
      pc_out_q     <= pc_out_d;
      hold_q       <= hold_d;
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign inst_valid = inst_valid_q;
  assign inst_out   = inst_out_q;
  assign pc_out     = pc_out_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: scripted memory responses, expected pushes
// queued when each ack is driven and compared when inst_valid appears.
module tb_fetch_ctrl;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        clear = 1'b0;
  logic [31:0] clear_pc = '0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_data = '0;
  logic        iq_wr_en = 1'b0;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [31:0] pc_out;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  exp_t sb[$];

  fetch_ctrl #(
    .RESET_PC     (32'h0),
    .ICACHE_IDX_W (4)
  ) dut (
    .clk_in     (clk),
    .rst_in     (rst),
    .rdy_in     (rdy),
    .clear      (clear),
    .clear_pc   (clear_pc),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_data   (mem_data),
    .iq_wr_en   (iq_wr_en),
    .inst_valid (inst_valid),
    .inst_out   (inst_out),
    .pc_out     (pc_out)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (mem_req === 1'b1) begin
        ok = 1'b1;
        return;
      end
      tick();
    end
  endtask

  task automatic send_ack(input logic [31:0] a, input bit push);
    exp_t e;
    mem_ack  = 1'b1;
    mem_data = word_of(a);
    if (push) begin
      e.pc   = a;
      e.data = word_of(a);
      e.cyc  = cyc + 1;
      sb.push_back(e);
    end
    tick();
    mem_ack  = 1'b0;
    mem_data = $urandom;
  endtask

  // Push monitor: every inst_valid must match the oldest expectation.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (inst_valid === 1'b1) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL push_unexpected: got pc=%h inst=%h cyc=%0d, required no push", pc_out, inst_out, cyc);
      end else begin
        e = sb.pop_front();
        if (pc_out !== e.pc || inst_out !== e.data || cyc != e.cyc) begin
          n_fail++;
          $display("FAIL push: got pc=%h inst=%h cyc=%0d, required pc=%h inst=%h cyc=%0d",
                   pc_out, inst_out, cyc, e.pc, e.data, e.cyc);
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    n_checks++;
    if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_mem_req: got %b, required 0", mem_req); end
    n_checks++;
    if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_mem_addr: got %h, required 0", mem_addr); end
    n_checks++;
    if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL rst_inst_valid: got %b, required 0", inst_valid); end
    n_checks++;
    if (inst_out !== 32'h0 || pc_out !== 32'h0) begin
      n_fail++; $display("FAIL rst_outputs: got inst=%h pc=%h, required 0/0", inst_out, pc_out);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_sequential();
    bit ok;
    logic [31:0] a;
    iq_wr_en = 1'b1;
    for (int unsigned k = 0; k < 3; k++) begin
      a = k * 4;
      wait_req(ok);
      n_checks++;
      if (!ok || mem_addr !== a) begin
        n_fail++; $display("FAIL seq_req: got req=%b addr=%h, required req=1 addr=%h", mem_req, mem_addr, a);
      end
      repeat (3) tick();
      n_checks++;
      if (mem_req !== 1'b1 || mem_addr !== a) begin
        n_fail++; $display("FAIL seq_req_hold: got req=%b addr=%h, required req=1 addr=%h", mem_req, mem_addr, a);
      end
      send_ack(a, 1'b1);
      n_checks++;
      if (mem_req !== 1'b0) begin n_fail++; $display("FAIL seq_req_drop: got %b, required 0", mem_req); end
    end
  endtask

  task automatic test_hold();
    bit ok;
    exp_t e;
    wait_req(ok);
    n_checks++;
    if (!ok || mem_addr !== 32'hC) begin
      n_fail++; $display("FAIL hold_req: got req=%b addr=%h, required req=1 addr=0000000c", mem_req, mem_addr);
    end
    repeat (3) tick();
    iq_wr_en = 1'b0;
    send_ack(32'hC, 1'b0);
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (mem_req !== 1'b0) begin n_fail++; $display("FAIL hold_no_req: got %b, required 0", mem_req); end
      mem_ack  = (i == 1);
      mem_data = $urandom;
      tick();
    end
    mem_ack  = 1'b0;
    iq_wr_en = 1'b1;
    e.pc   = 32'hC;
    e.data = word_of(32'hC);
    e.cyc  = cyc + 1;
    sb.push_back(e);
    tick();
  endtask

  task automatic test_clear_in_wait();
    bit ok;
    wait_req(ok);
    n_checks++;
    if (!ok || mem_addr !== 32'h10) begin
      n_fail++; $display("FAIL drain_req: got req=%b addr=%h, required req=1 addr=00000010", mem_req, mem_addr);
    end
    tick();
    clear = 1'b1; clear_pc = 32'h180;
    tick();
    clear_pc = 32'h100;
    tick();
    clear = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h10) begin
        n_fail++; $display("FAIL drain_hold: got req=%b addr=%h, required req=1 addr=00000010", mem_req, mem_addr);
      end
      tick();
    end
    send_ack(32'h10, 1'b0);
    n_checks++;
    if (mem_req !== 1'b0) begin n_fail++; $display("FAIL drain_done: got req=%b, required 0", mem_req); end
    tick();
    n_checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin
      n_fail++; $display("FAIL redirect_req: got req=%b addr=%h, required req=1 addr=00000100", mem_req, mem_addr);
    end
    repeat (2) tick();
    send_ack(32'h100, 1'b1);
  endtask

  task automatic test_clear_with_ack();
    bit ok;
    wait_req(ok);
    n_checks++;
    if (!ok || mem_addr !== 32'h104) begin
      n_fail++; $display("FAIL clrack_req: got req=%b addr=%h, required req=1 addr=00000104", mem_req, mem_addr);
    end
    repeat (2) tick();
    clear = 1'b1; clear_pc = 32'h200;
    send_ack(32'h104, 1'b0);
    clear = 1'b0;
    n_checks++;
    if (mem_req !== 1'b0) begin n_fail++; $display("FAIL clrack_no_drain: got req=%b, required 0", mem_req); end
    tick();
    n_checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h200) begin
      n_fail++; $display("FAIL clrack_redirect: got req=%b addr=%h, required req=1 addr=00000200", mem_req, mem_addr);
    end
    repeat (2) tick();
    send_ack(32'h200, 1'b1);
  endtask

  task automatic test_clear_hold_idle();
    bit ok;
    int c;
    wait_req(ok);
    n_checks++;
    if (!ok || mem_addr !== 32'h204) begin
      n_fail++; $display("FAIL clrhold_req: got req=%b addr=%h, required req=1 addr=00000204", mem_req, mem_addr);
    end
    repeat (2) tick();
    iq_wr_en = 1'b0;
    send_ack(32'h204, 1'b0);
    tick();
    clear = 1'b1; clear_pc = 32'h300;
    tick();
    clear = 1'b0;
    repeat (2) tick();
    clear = 1'b1; clear_pc = 32'h400; iq_wr_en = 1'b1;
    c = cyc;
    tick();
    clear = 1'b0;
    n_checks++;
    if (mem_req !== 1'b0) begin n_fail++; $display("FAIL idle_redirect_early: got req=%b at cyc %0d, required 0", mem_req, cyc); end
    tick();
    n_checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h400 || cyc != c + 2) begin
      n_fail++; $display("FAIL idle_redirect: got req=%b addr=%h cyc=%0d, required req=1 addr=00000400 cyc=%0d",
                         mem_req, mem_addr, cyc, c + 2);
    end
    repeat (2) tick();
    send_ack(32'h400, 1'b1);
  endtask

  task automatic test_rdy_freeze();
    bit ok;
    wait_req(ok);
    n_checks++;
    if (!ok || mem_addr !== 32'h404) begin
      n_fail++; $display("FAIL rdy_req: got req=%b addr=%h, required req=1 addr=00000404", mem_req, mem_addr);
    end
    tick();
    rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h404 || inst_valid !== 1'b0) begin
        n_fail++; $display("FAIL rdy_freeze: got req=%b addr=%h valid=%b, required req=1 addr=00000404 valid=0",
                           mem_req, mem_addr, inst_valid);
      end
    end
    rdy = 1'b1;
    tick();
    send_ack(32'h404, 1'b1);
  endtask

  task automatic test_async_reset();
    bit ok;
    wait_req(ok);
    n_checks++;
    if (!ok || mem_addr !== 32'h408) begin
      n_fail++; $display("FAIL arst_req: got req=%b addr=%h, required req=1 addr=00000408", mem_req, mem_addr);
    end
    tick();
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (mem_req !== 1'b0 || mem_addr !== 32'h0) begin
      n_fail++; $display("FAIL arst_immediate: got req=%b addr=%h, required req=0 addr=00000000", mem_req, mem_addr);
    end
    tick();
    rst = 1'b0;
    wait_req(ok);
    n_checks++;
    if (!ok || mem_addr !== 32'h0) begin
      n_fail++; $display("FAIL arst_restart: got req=%b addr=%h, required req=1 addr=00000000", mem_req, mem_addr);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    clear = 1'b1; clear_pc = 32'hFFFF_FFFC;
    tick();
    clear = 1'b0;
    tick();
    send_ack(32'h0, 1'b0);
    wait_req(ok);
    n_checks++;
    if (!ok || mem_addr !== 32'hFFFF_FFFC) begin
      n_fail++; $display("FAIL wrap_top: got req=%b addr=%h, required req=1 addr=fffffffc", mem_req, mem_addr);
    end
    repeat (2) tick();
    send_ack(32'hFFFF_FFFC, 1'b1);
    wait_req(ok);
    n_checks++;
    if (!ok || mem_addr !== 32'h0) begin
      n_fail++; $display("FAIL wrap_zero: got req=%b addr=%h, required req=1 addr=00000000", mem_req, mem_addr);
    end
    repeat (2) tick();
    send_ack(32'h0, 1'b1);
    iq_wr_en = 1'b0;
  endtask

  task automatic test_refetch();
    bit ok;
    int c;
    logic [31:0] a;
    rst = 1'b1;
    tick();
    rst = 1'b0; iq_wr_en = 1'b1;
    for (int unsigned k = 0; k < 4; k++) begin
      a = k * 4;
      wait_req(ok);
      n_checks++;
      if (!ok || mem_addr !== a) begin
        n_fail++; $display("FAIL refill_req: got req=%b addr=%h, required req=1 addr=%h", mem_req, mem_addr, a);
      end
      repeat (2) tick();
      send_ack(a, 1'b1);
    end
    iq_wr_en = 1'b0;
    tick();
    clear = 1'b1; clear_pc = 32'h0; iq_wr_en = 1'b1;
    c = cyc;
`ifdef ICACHE_EN
    for (int unsigned k = 0; k < 4; k++) begin
      exp_t e;
      e.pc   = k * 4;
      e.data = word_of(e.pc);
      e.cyc  = c + 2 + int'(k);
      sb.push_back(e);
    end
    tick();
    clear = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (mem_req !== 1'b0) begin n_fail++; $display("FAIL hit_no_req: got req=%b at cyc %0d, required 0", mem_req, cyc); end
      tick();
    end
    n_checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h10 || cyc != c + 6) begin
      n_fail++; $display("FAIL hit_then_miss: got req=%b addr=%h cyc=%0d, required req=1 addr=00000010 cyc=%0d",
                         mem_req, mem_addr, cyc, c + 6);
    end
    repeat (2) tick();
    send_ack(32'h10, 1'b1);
`else
    tick();
    clear = 1'b0;
    tick();
    n_checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0 || cyc != c + 2) begin
      n_fail++; $display("FAIL refetch_miss: got req=%b addr=%h cyc=%0d, required req=1 addr=00000000 cyc=%0d",
                         mem_req, mem_addr, cyc, c + 2);
    end
    repeat (2) tick();
    send_ack(32'h0, 1'b1);
`endif
    iq_wr_en = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, required test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_sequential();
    test_hold();
    test_clear_in_wait();
    test_clear_with_ack();
    test_clear_hold_idle();
    test_rdy_freeze();
    test_async_reset();
    test_wrap();
    test_refetch();
    repeat (4) tick();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL missing_pushes: got %0d outstanding, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
